// File: rtl/dhcp_vlg_pkg.sv
// Shared DHCP definitions: option code constants, the option-parser state
// encoding and the default set of tracked option codes.
package dhcp_vlg_pkg;

    localparam logic [7:0] DHCP_OPT_PAD = 8'd0;
    localparam logic [7:0] DHCP_OPT_END = 8'd255;

    // Channel 0 is the LSB entry: 53 (msg type), 1 (mask), 58 (T1), 59 (T2),
    // 51 (lease), 54 (server id), 3 (router), 6 (DNS).
    localparam logic [7:0][7:0] DHCP_OPT_CODES_DFLT =
        {8'd6, 8'd3, 8'd54, 8'd51, 8'd59, 8'd58, 8'd1, 8'd53};

    typedef enum logic [2:0] {
        IDLE,
        KIND,
        LEN,
        DATA,
        FLUSH,
        DONE
    } dhcp_opt_parse_fsm_t;

endpackage

// File: rtl/dhcp_vlg_opt_parse_if.sv
// Byte stream in, parsed option table out. The byte source uses the master
// view; the parser uses the slave view.
interface dhcp_vlg_opt_parse_if #(
    parameter int OPT_NUM = 8,
    parameter int MAX_PLD = 14
);
    logic                           in_val;
    logic [7:0]                     in_dat;
    logic                           in_sof;
    logic                           in_eof;
    logic [OPT_NUM-1:0]             opt_pres;
    logic [OPT_NUM*8-1:0]           opt_len;
    logic [OPT_NUM*MAX_PLD*8-1:0]   opt_dat;
    logic [OPT_NUM-1:0]             opt_trunc;
    logic [OPT_NUM-1:0]             opt_dup;
    logic                           done;
    logic                           err;

    modport master (
        output in_val, in_dat, in_sof, in_eof,
        input  opt_pres, opt_len, opt_dat, opt_trunc, opt_dup, done, err
    );

    modport slave (
        input  in_val, in_dat, in_sof, in_eof,
        output opt_pres, opt_len, opt_dat, opt_trunc, opt_dup, done, err
    );
endinterface

// File: rtl/dhcp_vlg_opt_parse.sv
// Streaming DHCP option (TLV) parser. Walks the option bytes that follow the
// magic cookie and captures up to OPT_NUM configured option codes into
// fixed-size payload registers, with presence/length/truncation/duplicate
// flags and a done/err completion pulse.
module dhcp_vlg_opt_parse
    import dhcp_vlg_pkg::*;
#(
    parameter int                       OPT_NUM       = 8,
    parameter int                       MAX_PLD       = 14,
    parameter logic [OPT_NUM-1:0][7:0]  OPT_CODES     = DHCP_OPT_CODES_DFLT,
    parameter int                       MAX_OPT_BYTES = 312
) (
    input  logic                 clk,
    input  logic                 rst,
    dhcp_vlg_opt_parse_if.slave  bus
);

    localparam int IDX_W = (OPT_NUM > 1) ? $clog2(OPT_NUM) : 1;
    localparam int PLD_W = (MAX_PLD > 1) ? $clog2(MAX_PLD) : 1;
    localparam int CNT_W = $clog2(MAX_OPT_BYTES + 1);

    dhcp_opt_parse_fsm_t state_reg, state_next, eff_state;

    logic               start, kind_acc, len_acc, data_acc, parse, fin_err, ovr;
    logic               hit_reg, skip_reg, silent_reg, err_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [7:0]         len_reg, rem_reg;
    logic [7:0]         wr_idx;
    logic [CNT_W-1:0]   cnt_reg, cnt_base;
    logic               cnt_last;

    logic [OPT_NUM-1:0] pres_reg, trunc_reg, dup_reg;
    logic [7:0]         len_arr [OPT_NUM];
    logic [7:0]         dat_arr [OPT_NUM][MAX_PLD];

    // Returns {hit, channel}; codes are assumed unique so at most one hits.
    function automatic logic [IDX_W:0] code_match(input logic [7:0] code);
        logic [IDX_W:0] m;
        m = '0;
        for (int i = 0; i < OPT_NUM; i++) begin
            if (OPT_CODES[i] == code) begin
                m = {1'b1, IDX_W'(i)};
            end
        end
        return m;
    endfunction

    // A new message restarts the count, so the sof byte is byte number one.
    assign cnt_base = start ? '0 : cnt_reg;
    assign cnt_last = (cnt_base >= CNT_W'(MAX_OPT_BYTES - 1));
    assign wr_idx   = len_reg - rem_reg;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and per-byte strobes; in_sof forces the byte to be treated
    // as an option kind byte whatever state we were in.
    always_comb begin
        state_next = state_reg;
        eff_state  = state_reg;
        start      = 1'b0;
        kind_acc   = 1'b0;
        len_acc    = 1'b0;
        data_acc   = 1'b0;
        parse      = 1'b0;
        fin_err    = 1'b0;
        ovr        = 1'b0;
        if (state_reg == DONE) begin
            state_next = silent_reg ? FLUSH : IDLE;
        end
        if (bus.in_val) begin
            start = bus.in_sof;
            if (bus.in_sof) begin
                eff_state = KIND;
            end
            case (eff_state)
                KIND: begin
                    if (bus.in_dat == DHCP_OPT_END) begin
                        state_next = bus.in_eof ? DONE : FLUSH;
                    end else begin
                        parse = 1'b1;
                        if (bus.in_dat == DHCP_OPT_PAD) begin
                            state_next = KIND;
                        end else begin
                            kind_acc   = 1'b1;
                            state_next = LEN;
                        end
                    end
                end
                LEN: begin
                    parse      = 1'b1;
                    len_acc    = 1'b1;
                    state_next = (bus.in_dat == 8'd0) ? KIND : DATA;
                end
                DATA: begin
                    parse      = 1'b1;
                    data_acc   = 1'b1;
                    state_next = (rem_reg == 8'd1) ? KIND : DATA;
                end
                FLUSH: begin
                    if (bus.in_eof) begin
                        state_next = silent_reg ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (silent_reg && bus.in_eof) begin
                        state_next = IDLE;
                    end
                end
                default: ;
            endcase
            // Running out of bytes anywhere but on/after END is malformed;
            // an overrun reports once and then drains the rest quietly.
            if (parse && bus.in_eof) begin
                state_next = DONE;
                fin_err    = 1'b1;
            end else if (parse && cnt_last) begin
                state_next = DONE;
                fin_err    = 1'b1;
                ovr        = 1'b1;
            end
        end
    end

    // Option table, message byte counter and per-option working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_reg    <= 1'b0;
            idx_reg    <= '0;
            skip_reg   <= 1'b1;
            silent_reg <= 1'b0;
            err_reg    <= 1'b0;
            len_reg    <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            pres_reg   <= '0;
            trunc_reg  <= '0;
            dup_reg    <= '0;
            for (int c = 0; c < OPT_NUM; c++) begin
                len_arr[c] <= '0;
                for (int b = 0; b < MAX_PLD; b++) begin
                    dat_arr[c][b] <= '0;
                end
            end
        end else begin
            if (start) begin
                silent_reg <= 1'b0;
                err_reg    <= 1'b0;
                pres_reg   <= '0;
                trunc_reg  <= '0;
                dup_reg    <= '0;
                for (int c = 0; c < OPT_NUM; c++) begin
                    len_arr[c] <= '0;
                    for (int b = 0; b < MAX_PLD; b++) begin
                        dat_arr[c][b] <= '0;
                    end
                end
            end
            if (bus.in_val && (start || state_reg != IDLE)) begin
                cnt_reg <= (cnt_base == CNT_W'(MAX_OPT_BYTES)) ? cnt_base : cnt_base + 1'b1;
            end
            if (kind_acc) begin
                {hit_reg, idx_reg} <= code_match(bus.in_dat);
            end
            if (len_acc) begin
                len_reg <= bus.in_dat;
                rem_reg <= bus.in_dat;
                if (hit_reg && !pres_reg[idx_reg]) begin
                    pres_reg[idx_reg]  <= 1'b1;
                    len_arr[idx_reg]   <= bus.in_dat;
                    trunc_reg[idx_reg] <= (bus.in_dat > 8'(MAX_PLD));
                    skip_reg           <= 1'b0;
                end else begin
                    // Untracked code or a repeat: walk the payload, store nothing.
                    skip_reg <= 1'b1;
                    if (hit_reg) begin
                        dup_reg[idx_reg] <= 1'b1;
                    end
                end
            end
            if (data_acc) begin
                rem_reg <= rem_reg - 8'd1;
                if (!skip_reg && wr_idx < 8'(MAX_PLD)) begin
                    dat_arr[idx_reg][wr_idx[PLD_W-1:0]] <= bus.in_dat;
                end
            end
            if (fin_err) begin
                err_reg <= 1'b1;
            end
            if (ovr) begin
                silent_reg <= 1'b1;
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < OPT_NUM; gi++) begin : g_ch
            assign bus.opt_len[gi*8 +: 8] = len_arr[gi];
            for (gj = 0; gj < MAX_PLD; gj++) begin : g_byte
                assign bus.opt_dat[(gi*MAX_PLD+gj)*8 +: 8] = dat_arr[gi][gj];
            end
        end
    endgenerate

    assign bus.opt_pres  = pres_reg;
    assign bus.opt_trunc = trunc_reg;
    assign bus.opt_dup   = dup_reg;
    assign bus.done      = (state_reg == DONE);
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_dhcp_vlg_opt_parse.sv
// Directed bench for the DHCP option parser: TLV messages with random valid
// gaps, checked every cycle against a message-level reference model.
module tb_dhcp_vlg_opt_parse;

    localparam int OPT_NUM       = 8;
    localparam int MAX_PLD       = 14;
    localparam int MAX_OPT_BYTES = 312;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dhcp_vlg_opt_parse_if #(.OPT_NUM(OPT_NUM), .MAX_PLD(MAX_PLD)) bus();

    dhcp_vlg_opt_parse #(
        .OPT_NUM       (OPT_NUM),
        .MAX_PLD       (MAX_PLD),
        .OPT_CODES     ({8'd6, 8'd3, 8'd54, 8'd51, 8'd59, 8'd58, 8'd1, 8'd53}),
        .MAX_OPT_BYTES (MAX_OPT_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = -1;

    int codes [OPT_NUM] = '{53, 1, 58, 59, 51, 54, 3, 6};

    logic       exp_pres  [OPT_NUM];
    logic [7:0] exp_len   [OPT_NUM];
    logic       exp_trunc [OPT_NUM];
    logic       exp_dup   [OPT_NUM];
    logic [7:0] exp_dat   [OPT_NUM][MAX_PLD];
    logic       exp_err;
    int         exp_term;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_exp();
        for (int c = 0; c < OPT_NUM; c++) begin
            exp_pres[c]  = 1'b0;
            exp_len[c]   = 8'd0;
            exp_trunc[c] = 1'b0;
            exp_dup[c]   = 1'b0;
            for (int b = 0; b < MAX_PLD; b++) exp_dat[c][b] = 8'd0;
        end
        exp_err  = 1'b0;
        exp_term = -1;
    endtask

    // Message-level model: walk the TLVs of one whole message. Bytes beyond
    // the overrun limit are never parsed; the terminating byte is the END
    // byte's eof, or the last parsed byte when the message is malformed.
    task automatic model(input bq_t m);
        int n, lim, i, l, ch, end_i;
        clear_exp();
        n   = m.size();
        lim = (n < MAX_OPT_BYTES) ? n : MAX_OPT_BYTES;
        i   = 0;
        while (exp_term < 0) begin
            if (m[i] == 8'hFF) begin
                exp_term = n - 1;
            end else if (i >= lim - 1) begin
                exp_term = lim - 1;
                exp_err  = 1'b1;
            end else if (m[i] == 8'h00) begin
                i++;
            end else begin
                l     = int'(m[i+1]);
                end_i = i + 1 + l;
                ch    = -1;
                for (int c = 0; c < OPT_NUM; c++) if (codes[c] == int'(m[i])) ch = c;
                if (ch >= 0) begin
                    if (exp_pres[ch]) begin
                        exp_dup[ch] = 1'b1;
                    end else begin
                        exp_pres[ch]  = 1'b1;
                        exp_len[ch]   = m[i+1];
                        exp_trunc[ch] = (l > MAX_PLD);
                        for (int j = 0; j < l && j < MAX_PLD; j++)
                            if (i + 2 + j <= lim - 1) exp_dat[ch][j] = m[i+2+j];
                    end
                end
                if (end_i >= lim - 1) begin
                    exp_term = lim - 1;
                    exp_err  = 1'b1;
                end else begin
                    i = end_i + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [MAX_PLD*8-1:0] e;
        chk("err", bus.err, exp_err);
        for (int c = 0; c < OPT_NUM; c++) begin
            for (int b = 0; b < MAX_PLD; b++) e[b*8 +: 8] = exp_dat[c][b];
            chk($sformatf("pres[%0d]", c),  bus.opt_pres[c],  exp_pres[c]);
            chk($sformatf("len[%0d]", c),   bus.opt_len[c*8 +: 8], exp_len[c]);
            chk($sformatf("trunc[%0d]", c), bus.opt_trunc[c], exp_trunc[c]);
            chk($sformatf("dup[%0d]", c),   bus.opt_dup[c],   exp_dup[c]);
            chk($sformatf("dat[%0d]", c),   bus.opt_dat[c*MAX_PLD*8 +: MAX_PLD*8], e);
        end
    endtask

    function automatic logic [7:0] dut_byte(input int c, input int b);
        return bus.opt_dat[(c*MAX_PLD+b)*8 +: 8];
    endfunction

    // Drive one message byte per cycle with random idle gaps; note the cycle
    // on which done must be seen (the one after the terminating byte).
    task automatic send(input bq_t m, input bit eof_en, input int term);
        int g;
        for (int k = 0; k < m.size(); k++) begin
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            repeat (g) begin
                bus.in_val = 1'b0;
                bus.in_sof = 1'b0;
                bus.in_eof = 1'b0;
                @(negedge clk);
            end
            bus.in_val = 1'b1;
            bus.in_dat = m[k];
            bus.in_sof = (k == 0);
            bus.in_eof = eof_en && (k == m.size() - 1);
            if (k == term) done_cyc = cyc + 1;
            @(negedge clk);
        end
        bus.in_val = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_eof = 1'b0;
    endtask

    task automatic run_msg(input string tag, input bq_t m);
        model(m);
        $display("msg %s: %0d bytes, done expected after byte %0d, err %0d", tag, m.size(), exp_term, exp_err);
        send(m, 1'b1, exp_term);
        repeat (6) @(negedge clk);
    endtask

    // Every cycle: done must pulse exactly when the model says; on done the
    // whole option table is compared with the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk($sformatf("done@%0d", cyc), bus.done, (cyc == done_cyc));
            if (bus.done) check_all();
        end
    end

    initial begin
        bq_t m;
        bus.in_val = 1'b0;
        bus.in_dat = 8'h00;
        bus.in_sof = 1'b0;
        bus.in_eof = 1'b0;
        clear_exp();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_pres", bus.opt_pres, 0);
        chk("rst_len", bus.opt_len, 0);
        chk("rst_dat_any", |bus.opt_dat, 0);
        chk("rst_err", bus.err, 0);
        @(negedge clk);

        m = '{8'h35, 8'h01, 8'h05, 8'h01, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        run_msg("basic", m);
        chk("t1_len53", bus.opt_len[7:0], 8'd1);
        chk("t1_dat53_0", dut_byte(0, 0), 8'h05);
        chk("t1_dat1_0", dut_byte(1, 0), 8'hFF);
        chk("t1_dat1_3", dut_byte(1, 3), 8'h00);
        chk("t1_err", bus.err, 1'b0);

        m = '{8'h00, 8'h00, 8'h0C, 8'h03, 8'h41, 8'h42, 8'h43, 8'h00,
              8'h33, 8'h04, 8'h00, 8'h01, 8'h51, 8'h80, 8'hFF};
        run_msg("pad_unknown", m);
        chk("t2_len51", bus.opt_len[4*8 +: 8], 8'd4);
        chk("t2_dat51_2", dut_byte(4, 2), 8'h51);

        m = '{8'h06, 8'd20};
        for (int k = 1; k <= 20; k++) m.push_back(8'(k));
        m = {m, '{8'h03, 8'h04, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hFF}};
        run_msg("trunc", m);
        chk("t3_len6", bus.opt_len[7*8 +: 8], 8'd20);
        chk("t3_trunc6", bus.opt_trunc[7], 1'b1);
        chk("t3_dat6_13", dut_byte(7, 13), 8'h0E);
        chk("t3_dat3_0", dut_byte(6, 0), 8'hC0);

        m = '{8'h36, 8'h04, 8'hC0, 8'hA8, 8'h00, 8'h01,
              8'h36, 8'h04, 8'h0A, 8'h00, 8'h00, 8'h01, 8'hFF};
        run_msg("dup", m);
        chk("t4_dup54", bus.opt_dup[5], 1'b1);
        chk("t4_dat54_0", dut_byte(5, 0), 8'hC0);

        m = '{8'h35, 8'h01, 8'h05, 8'h33, 8'h04, 8'hAA, 8'hBB};
        run_msg("eof_in_data", m);
        chk("t5_err", bus.err, 1'b1);
        chk("t5_dat51_1", dut_byte(4, 1), 8'hBB);
        chk("t5_dat51_2", dut_byte(4, 2), 8'h00);

        m = '{8'h35, 8'h01, 8'h02, 8'h00};
        run_msg("no_end", m);
        chk("t6_err", bus.err, 1'b1);

        m = '{8'h35, 8'h01, 8'h05, 8'h03, 8'h04};
        run_msg("eof_in_len", m);

        m = '{8'h35, 8'h01, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h00};
        run_msg("flush", m);
        chk("t8_err", bus.err, 1'b0);

        m = '{8'h0C, 8'hFF};
        for (int k = 0; k < 255; k++) m.push_back(8'(k));
        m = {m, '{8'h0C, 8'hFF}};
        while (m.size() < 330) m.push_back(8'h5A);
        run_msg("overrun", m);
        chk("t9_err", bus.err, 1'b1);
        chk("t9_pres", bus.opt_pres, 0);

        m = '{8'h35, 8'h01, 8'h05, 8'h01, 8'h04, 8'hAA};
        $display("msg restart: partial %0d bytes without eof", m.size());
        send(m, 1'b0, -1);
        m = '{8'h01, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFF};
        run_msg("restart", m);
        chk("t10_pres53", bus.opt_pres[0], 1'b0);
        chk("t10_dat1_3", dut_byte(1, 3), 8'h0D);

        m = '{8'h01, 8'h04, 8'h11, 8'h22};
        $display("msg rst_mid_data: partial %0d bytes then reset", m.size());
        send(m, 1'b0, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        clear_exp();
        chk("t11_pres", bus.opt_pres, 0);
        check_all();
        repeat (4) @(negedge clk);

        m = '{8'h3B, 8'h04, 8'h00, 8'h00, 8'h0E, 8'h10, 8'hFF};
        run_msg("after_rst", m);
        chk("t12_dat59_2", dut_byte(3, 2), 8'h0E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dhcp_vlg_opt_parse.md
Name: dhcp_vlg_opt_parse

Overview:
Streaming, parametrised DHCP option (TLV) parser. It consumes the UDP payload bytes that follow the 4-byte magic cookie and extracts up to OPT_NUM configurable option codes into fixed-size payload registers. Each extracted option gets a presence flag, length, truncation flag and duplicate flag. It replaces the fixed 16-byte, fixed-code option handling and sits between the UDP receive path and the DHCP client FSM.

Parameters:
OPT_NUM, 8, number of tracked option channels
MAX_PLD, 14, payload bytes stored per channel; longer options are truncated
OPT_CODES, {53,1,58,59,51,54,3,6}, packed [OPT_NUM-1:0][7:0]; the option code for each channel (index 0 = LSB entry)
MAX_OPT_BYTES, 312, maximum option bytes accepted per message before an overrun error is flagged

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_val  in  1  input byte valid
in_dat  in  8  input byte
in_sof  in  1  with in_val: first option byte (byte after cookie)
in_eof  in  1  with in_val: last payload byte
opt_pres  out  OPT_NUM  channel option found
opt_len  out  OPT_NUM*8  length field as received (not clipped)
opt_dat  out  OPT_NUM*MAX_PLD*8  payload; byte 0 = first payload byte; unused bytes are zero
opt_trunc  out  OPT_NUM  received length > MAX_PLD
opt_dup  out  OPT_NUM  code seen more than once; the first occurrence is kept
done  out  1  one-cycle pulse; all outputs are stable from this pulse until the next in_sof
err  out  1  valid with done: malformed message

Behaviour:
- Reset: all outputs 0, FSM in IDLE, byte counter 0.
- in_sof in any state starts a new message:
  - clears opt_pres, opt_len, opt_dat, opt_trunc, opt_dup and err;
  - processes the same byte as a KIND byte.
- States:
  - IDLE: bytes without in_sof are ignored.
  - KIND:
    - 0 (PAD): stay in KIND.
    - 255 (END): go to FLUSH.
    - Any other code: latch it, match it against OPT_CODES (combinational, at most one match), go to LEN.
  - LEN:
    - Latch len.
    - For a matched channel with no prior presence: set opt_pres, write opt_len, set opt_trunc if len > MAX_PLD.
    - For a matched channel with prior presence: set opt_dup and do not write.
    - len = 0 goes to KIND; otherwise go to DATA with remaining = len.
  - DATA:
    - Write payload byte index (len - remaining) to the matched channel only if that index < MAX_PLD and the channel is not a duplicate.
    - Decrement remaining; at 1, go to KIND.
  - FLUSH: ignore bytes until in_eof.
  - DONE: one cycle; pulse done; go to IDLE.
- Completion:
  - in_eof while in FLUSH, or an END byte arriving together with in_eof, goes to DONE. done is asserted the cycle after the in_eof byte, with err = 0.
  - in_eof in KIND (no END seen), LEN, or in DATA with remaining > 1: done is asserted next cycle with err = 1. Data collected so far is kept.
  - The byte counter reaching MAX_OPT_BYTES without END: err = 1, done is pulsed, then FLUSH to eof silently (no second done).
- Throughput: one byte per cycle; in_val may drop at any time and the FSM holds.
- Widths: remaining is 8 bit; the byte counter is $clog2(MAX_OPT_BYTES+1) bits and saturates.
- rst mid-message: immediate return to reset state; no done.

Decomposition:
- Add to dhcp_vlg_pkg:
  - the state enum dhcp_opt_parse_fsm_t (IDLE, KIND, LEN, DATA, FLUSH, DONE);
  - the DHCP_OPT_END / DHCP_OPT_PAD constants already defined there;
  - a default OPT_CODES localparam.
- No sub-module; the code-match function stays local.

Test Plan:
- Stream 35 01 05 | 01 04 FF FF FF 00 | FF, eof on FF -> done with err = 0. Channel 53: pres, len 1, dat[0] = 05. Channel 1: dat = FF FF FF 00.
- PAD bytes 00 00 between options, plus unknown code 0C 03 41 42 43 -> unknown option skipped; tracked channels parsed correctly; err = 0.
- Option 06 with len 20 (MAX_PLD = 14) -> opt_len = 20, opt_trunc set, first 14 bytes stored, next option parsed correctly.
- Code 36 appears twice (C0A80001 then 0A000001) -> first value kept, opt_dup set.
- eof during DATA (len 4, only 2 bytes sent) -> done next cycle with err = 1; missing END -> err = 1.
- Random in_val gaps; in_sof mid-message restarts cleanly; rst asserted mid-DATA -> all outputs 0 and no done.
